// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter with a valid/ready grant handshake: fixed-priority or round-robin, chosen at runtime by mode.
// Optional sticky grant (lock input) is compiled in when PRIO_ARB_LOCK_EN is defined.
module prio_arbiter_rr #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic             gnt_ready,
`ifdef PRIO_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic [CNT_W-1:0] gnt_cnt,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] arb_ptr;
    logic [IDX_W-1:0] winner;
    logic             handshake;
    logic             any_req;
    logic             hold_lock;
    logic             load;

    function automatic logic [IDX_W-1:0] fixed_pick(input logic [N-1:0] r);
        logic [IDX_W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++)
            if (r[i]) w = IDX_W'(i);
        return w;
    endfunction

    // First set bit strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] w;
        logic             found;
        int               j;
        w     = ptr;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && r[j]) begin
                w     = IDX_W'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign handshake = (state == GRANT) && gnt_ready;
    assign any_req   = |req;
    // The just-granted index is forwarded so back-to-back arbitration sees the updated pointer.
    assign arb_ptr   = handshake ? gnt_idx : rr_ptr;

`ifdef PRIO_ARB_LOCK_EN
    assign hold_lock = handshake && lock && req[gnt_idx];
`else
    assign hold_lock = 1'b0;
`endif

    assign winner = hold_lock ? gnt_idx
                  : (mode ? rr_pick(req, arb_ptr) : fixed_pick(req));
    assign load   = any_req && ((state == IDLE) || handshake);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: defaulting every comb output up front keeps unlisted paths from inferring latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   if (handshake && !any_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx <= '0;
            gnt_cnt <= '0;
            rr_ptr  <= IDX_W'(N - 1);
        end else begin
            if (load) gnt_idx <= winner;
            if (handshake) begin
                if (gnt_cnt != {CNT_W{1'b1}}) gnt_cnt <= gnt_cnt + CNT_W'(1);
                if (!hold_lock) rr_ptr <= gnt_idx;
            end
        end
    end

    always_comb begin
        gnt_valid  = (state == GRANT);
        busy       = (state == GRANT);
        gnt_onehot = '0;
        if (state == GRANT) gnt_onehot[gnt_idx] = 1'b1;
    end

endmodule
